// File: rtl/uart_tx_arb.sv
`default_nettype none
// ------------------------------------------------------------------------
// uart_tx_arb: round-robin arbiter/sequencer sharing one uart_tx. Rev 1.0
// ------------------------------------------------------------------------
module uart_tx_arb #(
  parameter int N       = 4,
  parameter int HOLD_TO = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [8*N-1:0]       req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_idle,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 locked,
  output logic                 err_timeout
);

  localparam int GW = $clog2(N);
  localparam int CW = $clog2(HOLD_TO + 1);
  localparam logic [GW:0]   N_EXT    = (GW + 1)'(N);
  localparam logic [GW-1:0] LAST_ID  = GW'(N - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_TO - 1);
  localparam logic [N-1:0]  ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ARB       = 3'd0,
    START     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    HOLD      = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] rr_ptr, rr_nxt;
  logic [CW-1:0] hold_cnt, cnt_nxt;
  logic [7:0]    data_nxt;
  logic          start_nxt;
  logic [N-1:0]  ready_nxt;
  logic [GW-1:0] gnt_nxt;
  logic          locked_nxt;
  logic          err_nxt;

  logic [7:0]    req_byte [N];
  logic [GW:0]   cand;
  logic          sel_found;
  logic [GW-1:0] sel_idx;
  logic [GW-1:0] gnt_inc;

  for (genvar g = 0; g < N; g++) begin : g_bytes
    assign req_byte[g] = req_data[8*g +: 8];
  end

  assign gnt_inc = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;

  // First valid requester at or above rr_ptr, wrapping modulo N.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, rr_ptr} + (GW + 1)'(i);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!sel_found && req_valid[cand[GW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_nxt     = rr_ptr;
    cnt_nxt    = hold_cnt;
    data_nxt   = tx_data;
    start_nxt  = 1'b0;
    ready_nxt  = '0;
    gnt_nxt    = gnt_id;
    locked_nxt = locked;
    err_nxt    = 1'b0;
    case (state)
      ARB: begin
        if (tx_idle && sel_found) begin
          data_nxt   = req_byte[sel_idx];
          ready_nxt  = ONE_HOT0 << sel_idx;
          gnt_nxt    = sel_idx;
          locked_nxt = ~req_last[sel_idx];
          state_nxt  = START;
        end
      end
      START: begin
        start_nxt = 1'b1;
        state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        // uart_tx drops idle one cycle after it samples the start pulse.
        if (!tx_idle) state_nxt = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (tx_idle) begin
          if (locked) begin
            cnt_nxt   = '0;
            state_nxt = HOLD;
          end else begin
            rr_nxt    = gnt_inc;
            state_nxt = ARB;
          end
        end
      end
      HOLD: begin
        if (req_valid[gnt_id]) begin
          data_nxt   = req_byte[gnt_id];
          ready_nxt  = ONE_HOT0 << gnt_id;
          locked_nxt = ~req_last[gnt_id];
          cnt_nxt    = '0;
          state_nxt  = START;
        end else if (hold_cnt == CNT_LAST) begin
          err_nxt    = 1'b1;
          locked_nxt = 1'b0;
          rr_nxt     = gnt_inc;
          cnt_nxt    = '0;
          state_nxt  = ARB;
        end else begin
          cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      req_ready   <= '0;
      gnt_id      <= '0;
      locked      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_nxt;
      hold_cnt    <= cnt_nxt;
      tx_data     <= data_nxt;
      tx_start    <= start_nxt;
      req_ready   <= ready_nxt;
      gnt_id      <= gnt_nxt;
      locked      <= locked_nxt;
      err_timeout <= err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_uart_tx_arb: directed bench for uart_tx_arb (N=4, HOLD_TO=16). Rev 1.0
// ------------------------------------------------------------------------
module tb_uart_tx_arb;

  localparam int N       = 4;
  localparam int HOLD_TO = 16;
  localparam int FRAME   = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_idle;
  logic [1:0]  gnt_id;
  logic        locked;
  logic        err_timeout;

  int checks = 0;
  int fails  = 0;

  uart_tx_arb #(.N(N), .HOLD_TO(HOLD_TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_idle    (tx_idle),
    .gnt_id     (gnt_id),
    .locked     (locked),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]        = v;
    req_data[8*i +: 8]  = d;
    req_last[i]         = l;
  endtask

  task automatic chk_reset_outputs;
    chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_gnt_id", {30'd0, gnt_id}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
  endtask

  // Waits for the grant, then plays uart_tx for one frame while scrambling req_data[7:0].
  task automatic run_frame(input int idx, input logic [7:0] d, input logic lk);
    int n;
    logic [7:0] saved;
    n = 0;
    while (req_ready == 4'd0 && n < 40) begin
      tick;
      n++;
    end
    chk("grant_ready", {28'd0, req_ready}, 32'd1 << idx);
    chk("grant_id", {30'd0, gnt_id}, 32'(idx));
    chk("grant_data", {24'd0, tx_data}, {24'd0, d});
    chk("grant_locked", {31'd0, locked}, {31'd0, lk});
    tick;
    chk("start_high", {31'd0, tx_start}, 32'd1);
    chk("ready_pulse_end", {28'd0, req_ready}, 32'd0);
    tick;
    chk("start_low", {31'd0, tx_start}, 32'd0);
    tx_idle = 1'b0;
    saved = req_data[7:0];
    for (int c = 0; c < FRAME; c++) begin
      req_data[7:0] = 8'($urandom);
      tick;
      chk("data_stable", {24'd0, tx_data}, {24'd0, d});
    end
    req_data[7:0] = saved;
    tx_idle = 1'b1;
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_idle   = 1'b1;
    repeat (3) tick;
    chk_reset_outputs();
    rst_n = 1'b1;
    tick;

    // Fairness: all four valid with single-byte packets.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'h10 + 8'(i), 1'b1);
    run_frame(0, 8'h10, 1'b0);
    run_frame(1, 8'h11, 1'b0);
    run_frame(2, 8'h12, 1'b0);
    run_frame(3, 8'h13, 1'b0);
    run_frame(0, 8'h10, 1'b0);
    req_valid = '0;

    // Single byte from req0 with rr_ptr=1: search wraps to 0.
    set_req(0, 1'b1, 8'hA5, 1'b1);
    run_frame(0, 8'hA5, 1'b0);
    req_valid[0] = 1'b0;

    // Packet lock: req1 sends 11,22,33 while req0 waits.
    set_req(0, 1'b1, 8'h77, 1'b1);
    set_req(1, 1'b1, 8'h11, 1'b0);
    run_frame(1, 8'h11, 1'b1);
    set_req(1, 1'b1, 8'h22, 1'b0);
    run_frame(1, 8'h22, 1'b1);
    set_req(1, 1'b1, 8'h33, 1'b1);
    run_frame(1, 8'h33, 1'b0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    run_frame(0, 8'h77, 1'b0);
    set_req(0, 1'b0, 8'h00, 1'b0);

    // Timeout: req2 opens a packet and goes silent, req3 pending.
    set_req(3, 1'b1, 8'h3C, 1'b1);
    set_req(2, 1'b1, 8'h5E, 1'b0);
    run_frame(2, 8'h5E, 1'b1);
    req_valid[2] = 1'b0;
    for (int c = 1; c <= HOLD_TO; c++) begin
      tick;
      chk("no_early_timeout", {31'd0, err_timeout}, 32'd0);
      chk("no_grant_in_hold", {28'd0, req_ready}, 32'd0);
    end
    tick;
    chk("timeout_pulse", {31'd0, err_timeout}, 32'd1);
    chk("timeout_unlock", {31'd0, locked}, 32'd0);
    run_frame(3, 8'h3C, 1'b0);
    chk("timeout_pulse_end", {31'd0, err_timeout}, 32'd0);
    set_req(3, 1'b0, 8'h00, 1'b0);

    // Reset in the middle of a frame.
    set_req(1, 1'b1, 8'h5A, 1'b1);
    n = 0;
    while (req_ready == 4'd0 && n < 40) begin
      tick;
      n++;
    end
    chk("mid_ready", {28'd0, req_ready}, 32'h2);
    tick;
    chk("mid_start", {31'd0, tx_start}, 32'd1);
    tick;
    tx_idle = 1'b0;
    repeat (3) tick;
    rst_n     = 1'b0;
    req_valid = '0;
    tx_idle   = 1'b1;
    #1;
    chk_reset_outputs();
    tick;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("post_rst_no_start", {31'd0, tx_start}, 32'd0);
    end
    set_req(2, 1'b1, 8'hC3, 1'b1);
    run_frame(2, 8'hC3, 1'b0);
    req_valid = '0;
    repeat (4) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
